mux_arb: RTL

//   Packet-level round-robin arbiter that drives the one-hot 'sel' of the 2:1 router output mux.
//   It sits directly upstream of the mux: input-buffer heads request here, and the winner owns
//   the output from HEAD flit to TAIL flit (wormhole lock). It issues per-port pop grants and
//   a packet-length watchdog that force-releases a stuck lock.

---
 rtl/mux_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_arb.sv
// Packet-level round-robin arbiter for the 2:1 router output mux.
// Wormhole lock from HEAD to TAIL, with a packet-length watchdog.
`ifndef TYPE_NONE
`define TYPE_NONE 2'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'd3
`endif

module mux_arb #(
  parameter int NPORT  = 2,
  parameter int TYPEW  = 2,
  parameter int VCHW   = 2,
  parameter int MAXLEN = 64
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic [VCHW-1:0]  ivch_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic [VCHW-1:0]  ivch_1,
  input  logic             oready,
  output logic [NPORT-1:0] sel,
  output logic             grant_0,
  output logic             grant_1,
  output logic [VCHW-1:0]  ovch,
  output logic             busy,
  output logic             err_len
);

  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAXLEN);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(`TYPE_HEAD);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(`TYPE_TAIL);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t           r_state, w_state_n;
  logic [NPORT-1:0] r_sel, w_sel_n;
  logic [VCHW-1:0]  r_ovch, w_ovch_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             r_ptr, w_ptr_n;
  logic             r_err, w_err_n;

  logic             w_req0, w_req1, w_win;
  logic             w_gnt, w_tail;
  logic [TYPEW-1:0] w_gtype;
  logic [CW-1:0]    w_cnt_inc;

  assign w_req0 = ivalid_0 & (itype_0 == T_HEAD);
  assign w_req1 = ivalid_1 & (itype_1 == T_HEAD);
  // Pointer holds the last winner; a tie goes to the other port.
  assign w_win  = (w_req0 & w_req1) ? ~r_ptr : w_req1;

  assign grant_0 = r_sel[0] & ivalid_0 & oready;
  assign grant_1 = r_sel[1] & ivalid_1 & oready;

  assign w_gnt     = grant_0 | grant_1;
  assign w_gtype   = r_sel[1] ? itype_1 : itype_0;
  assign w_tail    = w_gnt & (w_gtype == T_TAIL);
  assign w_cnt_inc = (r_cnt == MAXC) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_ovch_n  = r_ovch;
    w_cnt_n   = r_cnt;
    w_ptr_n   = r_ptr;
    w_err_n   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_state_n = S_LOCK;
          w_sel_n   = w_win ? NPORT'(2) : NPORT'(1);
          w_ovch_n  = w_win ? ivch_1 : ivch_0;
          w_cnt_n   = '0;
          w_ptr_n   = w_win;
        end
      end
      S_LOCK: begin
        if (w_gnt) begin
          w_cnt_n = w_cnt_inc;
          if (w_tail) begin
            w_state_n = S_IDLE;
            w_sel_n   = '0;
          end else if (w_cnt_inc == MAXC) begin
            w_state_n = S_IDLE;
            w_sel_n   = '0;
            w_err_n   = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_sel_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_ovch  <= '0;
      r_cnt   <= '0;
      r_ptr   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sel   <= w_sel_n;
      r_ovch  <= w_ovch_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_err   <= w_err_n;
    end
  end

  assign sel     = r_sel;
  assign ovch    = r_ovch;
  assign busy    = (r_state == S_LOCK);
  assign err_len = r_err;

endmodule
